// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - shared encodings for the execute stage and its iterative multiplier
package exec_pkg;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SLT   = 4'b0101;
    localparam logic [3:0] ALU_SLTU  = 4'b0110;
    localparam logic [3:0] ALU_SLL   = 4'b0111;
    localparam logic [3:0] ALU_SRL   = 4'b1000;
    localparam logic [3:0] ALU_SRA   = 4'b1001;
    localparam logic [3:0] ALU_MUL   = 4'b1010;
    localparam logic [3:0] ALU_MULHU = 4'b1011;
    localparam logic [3:0] ALU_PASSB = 4'b1100;

    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_W   = 2'b01;
    localparam logic [1:0] FWD_M   = 2'b10;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'b00,
        MUL_BUSY = 2'b01,
        MUL_DONE = 2'b10
    } mul_state_e;

    function automatic logic is_mul_op(input logic [3:0] op);
        return (op == ALU_MUL) || (op == ALU_MULHU);
    endfunction

endpackage

// File: rtl/mul_iterative.sv
// rtl/mul_iterative.sv - radix-2 shift-add multiplier, one partial product per cycle
module mul_iterative
    import exec_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int MUL_STEPS = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic [XLEN-1:0]   op_a_i,
    input  logic [XLEN-1:0]   op_b_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [2*XLEN-1:0] product_o
);

    localparam int CNT_W = $clog2(MUL_STEPS);

    mul_state_e          state_q;
    logic                busy_q;
    logic                done_q;
    logic [XLEN-1:0]     mcand_q;
    logic [XLEN-1:0]     mplier_q;
    logic [2*XLEN-1:0]   acc_q;
    logic [CNT_W-1:0]    count_q;
    logic [XLEN:0]       partial;

    // Upper half gathers the partial sum while the whole accumulator shifts right,
    // so after MUL_STEPS steps the full product sits in acc_q.
    assign partial = {1'b0, acc_q[2*XLEN-1:XLEN]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= MUL_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
        end else begin
            case (state_q)
                MUL_IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        mcand_q  <= op_a_i;
                        mplier_q <= op_b_i;
                        acc_q    <= '0;
                        count_q  <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= MUL_BUSY;
                    end
                end
                MUL_BUSY: begin
                    acc_q    <= {partial, acc_q[XLEN-1:1]};
                    mplier_q <= mplier_q >> 1;
                    count_q  <= count_q + CNT_W'(1);
                    if (count_q == CNT_W'(MUL_STEPS - 1)) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= MUL_DONE;
                    end
                end
                MUL_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= MUL_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= MUL_IDLE;
                end
            endcase
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign product_o = acc_q;

endmodule

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - EX stage: forwarding, ALU, branch resolve, EX/MEM register; EXEC_PERF_CNT_EN adds counters
module execute_stage
    import exec_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int MUL_STEPS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            reg_write_enE,
    input  logic            mem_write_enE,
    input  logic            jumpE,
    input  logic            branchE,
    input  logic            alu_srcE,
    input  logic            jalrE,
    input  logic [1:0]      result_srcE,
    input  logic [3:0]      alu_controlE,
    input  logic [2:0]      funct3E,
    input  logic [XLEN-1:0] RD1E,
    input  logic [XLEN-1:0] RD2E,
    input  logic [XLEN-1:0] pcE,
    input  logic [XLEN-1:0] imm_extE,
    input  logic [XLEN-1:0] pc_plus_4E,
    input  logic [4:0]      rdE,
    input  logic [1:0]      forward_aE,
    input  logic [1:0]      forward_bE,
    input  logic [XLEN-1:0] resultW,
    output logic            pc_srcE,
    output logic [XLEN-1:0] pc_targetE,
    output logic            stall_mulE,
    output logic            reg_write_enM,
    output logic            mem_write_enM,
    output logic [1:0]      result_srcM,
    output logic [XLEN-1:0] alu_resultM,
    output logic [XLEN-1:0] write_dataM,
    output logic [XLEN-1:0] pc_plus_4M,
    output logic [4:0]      rdM
`ifdef EXEC_PERF_CNT_EN
    ,
    output logic [XLEN-1:0] branch_taken_cntE,
    output logic [XLEN-1:0] mul_stall_cntE
`endif
);

    logic [XLEN-1:0]   src_a;
    logic [XLEN-1:0]   src_b;
    logic [XLEN-1:0]   write_data;
    logic [XLEN-1:0]   alu_result;
    logic [4:0]        shamt;
    logic              branch_cond;
    logic              is_mul;
    logic              stall;
    logic              mul_busy;
    logic              mul_done;
    logic [2*XLEN-1:0] mul_product;

    logic              reg_write_en_q, reg_write_en_d;
    logic              mem_write_en_q, mem_write_en_d;
    logic [1:0]        result_src_q,   result_src_d;
    logic [XLEN-1:0]   alu_result_q,   alu_result_d;
    logic [XLEN-1:0]   write_data_q,   write_data_d;
    logic [XLEN-1:0]   pc_plus_4_q,    pc_plus_4_d;
    logic [4:0]        rd_q,           rd_d;

    always_comb begin
        case (forward_aE)
            FWD_W:   src_a = resultW;
            FWD_M:   src_a = alu_result_q;
            default: src_a = RD1E;
        endcase
        case (forward_bE)
            FWD_W:   write_data = resultW;
            FWD_M:   write_data = alu_result_q;
            default: write_data = RD2E;
        endcase
    end

    assign src_b = alu_srcE ? imm_extE : write_data;
    assign shamt = src_b[4:0];

    always_comb begin
        alu_result = '0;
        case (alu_controlE)
            ALU_ADD:   alu_result = src_a + src_b;
            ALU_SUB:   alu_result = src_a - src_b;
            ALU_AND:   alu_result = src_a & src_b;
            ALU_OR:    alu_result = src_a | src_b;
            ALU_XOR:   alu_result = src_a ^ src_b;
            ALU_SLT:   alu_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            ALU_SLTU:  alu_result = {{(XLEN-1){1'b0}}, (src_a < src_b)};
            ALU_SLL:   alu_result = src_a << shamt;
            ALU_SRL:   alu_result = src_a >> shamt;
            ALU_SRA:   alu_result = $signed(src_a) >>> shamt;
            ALU_MUL:   alu_result = mul_product[XLEN-1:0];
            ALU_MULHU: alu_result = mul_product[2*XLEN-1:XLEN];
            ALU_PASSB: alu_result = src_b;
            default:   alu_result = '0;
        endcase
    end

    always_comb begin
        branch_cond = 1'b0;
        case (funct3E)
            BR_EQ:   branch_cond = (src_a == write_data);
            BR_NE:   branch_cond = (src_a != write_data);
            BR_LT:   branch_cond = ($signed(src_a) <  $signed(write_data));
            BR_GE:   branch_cond = ($signed(src_a) >= $signed(write_data));
            BR_LTU:  branch_cond = (src_a <  write_data);
            BR_GEU:  branch_cond = (src_a >= write_data);
            default: branch_cond = 1'b0;
        endcase
    end

    // The multiplier ignores start outside IDLE, so a MUL held in E during DONE
    // does not relaunch; the DONE cycle is the one that drops the stall.
    assign is_mul = is_mul_op(alu_controlE);
    assign stall  = mul_busy | (is_mul & ~mul_done);

    mul_iterative #(
        .XLEN      (XLEN),
        .MUL_STEPS (MUL_STEPS)
    ) u_mul (
        .clk       (clk),
        .reset     (reset),
        .start_i   (is_mul),
        .op_a_i    (src_a),
        .op_b_i    (src_b),
        .busy_o    (mul_busy),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    assign stall_mulE = stall;
    assign pc_srcE    = ~stall & (jumpE | (branchE & branch_cond));
    assign pc_targetE = jalrE ? ((src_a + imm_extE) & ~XLEN'(1)) : (pcE + imm_extE);

    always_comb begin
        reg_write_en_d = 1'b0;
        mem_write_en_d = 1'b0;
        result_src_d   = '0;
        alu_result_d   = '0;
        write_data_d   = '0;
        pc_plus_4_d    = '0;
        rd_d           = '0;
        if (!stall) begin
            reg_write_en_d = reg_write_enE;
            mem_write_en_d = mem_write_enE;
            result_src_d   = result_srcE;
            alu_result_d   = alu_result;
            write_data_d   = write_data;
            pc_plus_4_d    = pc_plus_4E;
            rd_d           = rdE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reg_write_en_q <= 1'b0;
            mem_write_en_q <= 1'b0;
            result_src_q   <= '0;
            alu_result_q   <= '0;
            write_data_q   <= '0;
            pc_plus_4_q    <= '0;
            rd_q           <= '0;
        end else begin
            reg_write_en_q <= reg_write_en_d;
            mem_write_en_q <= mem_write_en_d;
            result_src_q   <= result_src_d;
            alu_result_q   <= alu_result_d;
            write_data_q   <= write_data_d;
            pc_plus_4_q    <= pc_plus_4_d;
            rd_q           <= rd_d;
        end
    end

    assign reg_write_enM = reg_write_en_q;
    assign mem_write_enM = mem_write_en_q;
    assign result_srcM   = result_src_q;
    assign alu_resultM   = alu_result_q;
    assign write_dataM   = write_data_q;
    assign pc_plus_4M    = pc_plus_4_q;
    assign rdM           = rd_q;

`ifdef EXEC_PERF_CNT_EN
    logic [XLEN-1:0] branch_taken_cnt_q;
    logic [XLEN-1:0] mul_stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            branch_taken_cnt_q <= '0;
            mul_stall_cnt_q    <= '0;
        end else begin
            if (pc_srcE) branch_taken_cnt_q <= branch_taken_cnt_q + XLEN'(1);
            if (stall)   mul_stall_cnt_q    <= mul_stall_cnt_q + XLEN'(1);
        end
    end

    assign branch_taken_cntE = branch_taken_cnt_q;
    assign mul_stall_cntE    = mul_stall_cnt_q;
`endif

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - randomized scoreboard bench for execute_stage
module tb_execute_stage;

    logic        clk;
    logic        reset;
    logic        reg_write_enE, mem_write_enE, jumpE, branchE, alu_srcE, jalrE;
    logic [1:0]  result_srcE;
    logic [3:0]  alu_controlE;
    logic [2:0]  funct3E;
    logic [31:0] RD1E, RD2E, pcE, imm_extE, pc_plus_4E, resultW;
    logic [4:0]  rdE;
    logic [1:0]  forward_aE, forward_bE;
    logic        pc_srcE, stall_mulE, reg_write_enM, mem_write_enM;
    logic [31:0] pc_targetE, alu_resultM, write_dataM, pc_plus_4M;
    logic [1:0]  result_srcM;
    logic [4:0]  rdM;

    execute_stage dut (
        .clk           (clk),
        .reset         (reset),
        .reg_write_enE (reg_write_enE),
        .mem_write_enE (mem_write_enE),
        .jumpE         (jumpE),
        .branchE       (branchE),
        .alu_srcE      (alu_srcE),
        .jalrE         (jalrE),
        .result_srcE   (result_srcE),
        .alu_controlE  (alu_controlE),
        .funct3E       (funct3E),
        .RD1E          (RD1E),
        .RD2E          (RD2E),
        .pcE           (pcE),
        .imm_extE      (imm_extE),
        .pc_plus_4E    (pc_plus_4E),
        .rdE           (rdE),
        .forward_aE    (forward_aE),
        .forward_bE    (forward_bE),
        .resultW       (resultW),
        .pc_srcE       (pc_srcE),
        .pc_targetE    (pc_targetE),
        .stall_mulE    (stall_mulE),
        .reg_write_enM (reg_write_enM),
        .mem_write_enM (mem_write_enM),
        .result_srcM   (result_srcM),
        .alu_resultM   (alu_resultM),
        .write_dataM   (write_dataM),
        .pc_plus_4M    (pc_plus_4M),
        .rdM           (rdM)
    );

    typedef struct {
        bit          chk_comb;
        logic        stall;
        logic        pcsrc;
        logic [31:0] tgt;
        logic        rw;
        logic        mw;
        logic [1:0]  rs;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [31:0] pc4;
        logic [4:0]  rd;
    } exp_t;

    exp_t        q[$];
    exp_t        pend;
    bit          have_pend;
    bit          first;
    int          checks;
    int          failures;
    logic [31:0] prev_alu;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] reg_v);
        if (sel == 2'b01) return resultW;
        if (sel == 2'b10) return prev_alu;
        return reg_v;
    endfunction

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int          sh;
        int          sa;
        int          sb;
        logic [63:0] ext;
        sh  = int'(b[4:0]);
        sa  = a;
        sb  = b;
        ext = {{32{a[31]}}, a};
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return (sa < sb) ? 32'd1 : 32'd0;
            4'd6:    return (a < b) ? 32'd1 : 32'd0;
            4'd7:    return a << sh;
            4'd8:    return a >> sh;
            4'd9:    return 32'(ext >> sh);
            4'd12:   return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit br_ref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        sa = a;
        sb = b;
        case (f3)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return sa < sb;
            3'd5:    return sa >= sb;
            3'd6:    return a < b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // One clock of stimulus: expected outcome is derived from current inputs and queued.
    task automatic cycle(input bit rst, input bit st, input bit done, input logic [63:0] prod);
        exp_t        e;
        logic [31:0] a, wd, b;
        reset = rst;
        a  = fwd(forward_aE, RD1E);
        wd = fwd(forward_bE, RD2E);
        b  = alu_srcE ? imm_extE : wd;
        e.chk_comb = !first;
        first      = 1'b0;
        e.stall    = st;
        e.pcsrc    = st ? 1'b0 : (jumpE | (branchE & br_ref(funct3E, a, wd)));
        e.tgt      = jalrE ? ((a + imm_extE) & 32'hFFFF_FFFE) : (pcE + imm_extE);
        if (rst || st) begin
            e.rw = 0; e.mw = 0; e.rs = 0; e.alu = 0; e.wd = 0; e.pc4 = 0; e.rd = 0;
        end else begin
            e.rw  = reg_write_enE;
            e.mw  = mem_write_enE;
            e.rs  = result_srcE;
            e.alu = done ? ((alu_controlE == 4'b1010) ? prod[31:0] : prod[63:32])
                         : alu_ref(alu_controlE, a, b);
            e.wd  = wd;
            e.pc4 = pc_plus_4E;
            e.rd  = rdE;
        end
        prev_alu = e.alu;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic set_plain(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        alu_controlE = op; RD1E = a; RD2E = b;
        forward_aE = 2'b00; forward_bE = 2'b00; alu_srcE = 1'b0;
        branchE = 1'b0; jumpE = 1'b0; jalrE = 1'b0;
        reg_write_enE = 1'b1; mem_write_enE = 1'b0; result_srcE = 2'b00;
        funct3E = 3'd0; rdE = 5'($urandom); pcE = $urandom; imm_extE = $urandom; pc_plus_4E = $urandom;
    endtask

    task automatic rand_op();
        logic [3:0] op;
        do op = 4'($urandom_range(0, 15)); while (op == 4'd10 || op == 4'd11);
        alu_controlE  = op;
        reg_write_enE = 1'($urandom); mem_write_enE = 1'($urandom);
        result_srcE   = 2'($urandom); funct3E = 3'($urandom);
        RD1E = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
        RD2E = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
        imm_extE = $urandom; pcE = $urandom; pc_plus_4E = $urandom; rdE = 5'($urandom);
        resultW  = $urandom; alu_srcE = 1'($urandom); jalrE = 1'($urandom);
        forward_aE = 2'($urandom_range(0, 2)); forward_bE = 2'($urandom_range(0, 2));
        branchE = 1'($urandom); jumpE = ($urandom_range(0, 4) == 0);
        cycle(1'b0, 1'b0, 1'b0, 64'd0);
    endtask

    // Holds the op in E as the hazard unit would while forwarding sources wander.
    task automatic do_mul(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] prod;
        set_plain(op, x, y);
        prod = {32'd0, x} * {32'd0, y};
        cycle(1'b0, 1'b1, 1'b0, 64'd0);
        for (int i = 0; i < 32; i++) begin
            forward_aE = 2'($urandom_range(0, 2));
            forward_bE = 2'($urandom_range(0, 2));
            resultW    = $urandom;
            jumpE      = 1'($urandom);
            cycle(1'b0, 1'b1, 1'b0, 64'd0);
        end
        cycle(1'b0, 1'b0, 1'b1, prod);
    endtask

    initial begin
        have_pend = 1'b0;
        forever begin
            @(negedge clk);
            if (have_pend) begin
                chk("reg_write_enM", reg_write_enM, pend.rw);
                chk("mem_write_enM", mem_write_enM, pend.mw);
                chk("result_srcM",   result_srcM,   pend.rs);
                chk("alu_resultM",   alu_resultM,   pend.alu);
                chk("write_dataM",   write_dataM,   pend.wd);
                chk("pc_plus_4M",    pc_plus_4M,    pend.pc4);
                chk("rdM",           rdM,           pend.rd);
            end
            if (q.size() > 0) begin
                pend = q.pop_front();
                have_pend = 1'b1;
                if (pend.chk_comb) begin
                    chk("stall_mulE", stall_mulE, pend.stall);
                    chk("pc_srcE",    pc_srcE,    pend.pcsrc);
                    chk("pc_targetE", pc_targetE, pend.tgt);
                end
            end else begin
                have_pend = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; failures = 0; prev_alu = 32'd0; first = 1'b1;
        reset = 1'b1;
        reg_write_enE = 0; mem_write_enE = 0; jumpE = 0; branchE = 0; alu_srcE = 0; jalrE = 0;
        result_srcE = 0; alu_controlE = 0; funct3E = 0; RD1E = 0; RD2E = 0; pcE = 0;
        imm_extE = 0; pc_plus_4E = 0; rdE = 0; forward_aE = 0; forward_bE = 0; resultW = 0;
        @(posedge clk);
        #1;
        cycle(1'b1, 1'b0, 1'b0, 64'd0);
        cycle(1'b1, 1'b0, 1'b0, 64'd0);

        // forwarding from M: first produce 5, then 5 + 7
        set_plain(4'd0, 32'd5, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 64'd0);
        set_plain(4'd0, 32'hDEAD_BEEF, 32'd7);
        forward_aE = 2'b10;
        cycle(1'b0, 1'b0, 1'b0, 64'd0);

        // BEQ taken / not taken
        set_plain(4'd0, 32'd3, 32'd3);
        branchE = 1'b1; funct3E = 3'd0; pcE = 32'h100; imm_extE = 32'h20; alu_srcE = 1'b1;
        cycle(1'b0, 1'b0, 1'b0, 64'd0);
        RD2E = 32'd4;
        cycle(1'b0, 1'b0, 1'b0, 64'd0);

        // BLT vs BLTU on -1 and 1
        set_plain(4'd0, 32'hFFFF_FFFF, 32'd1);
        branchE = 1'b1; funct3E = 3'd4;
        cycle(1'b0, 1'b0, 1'b0, 64'd0);
        funct3E = 3'd6;
        cycle(1'b0, 1'b0, 1'b0, 64'd0);
        funct3E = 3'd2;
        cycle(1'b0, 1'b0, 1'b0, 64'd0);

        // JALR clears bit 0 of the target
        set_plain(4'd0, 32'h0000_1001, 32'd0);
        jumpE = 1'b1; jalrE = 1'b1; imm_extE = 32'h0000_0010;
        cycle(1'b0, 1'b0, 1'b0, 64'd0);

        // back-to-back multiplies
        do_mul(4'd10, 32'd7, 32'd6);
        do_mul(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // reset while BUSY at step 10, then a fresh multiply
        set_plain(4'd10, 32'h1234_5678, 32'h9ABC_DEF0);
        cycle(1'b0, 1'b1, 1'b0, 64'd0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b0, 64'd0);
        cycle(1'b1, 1'b1, 1'b0, 64'd0);
        set_plain(4'd0, 32'd11, 32'd22);
        cycle(1'b0, 1'b0, 1'b0, 64'd0);
        do_mul(4'd10, 32'd123456, 32'd654321);

        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 11) == 0)
                do_mul(($urandom_range(0, 1) == 0) ? 4'd10 : 4'd11, $urandom, $urandom);
            else
                rand_op();
        end

        set_plain(4'd0, 32'd0, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 64'd0);
        repeat (3) @(negedge clk);
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
